// File: rtl/irq_timer_pkg.sv
// Shared constants for the machine-mode timer/interrupt block: register offsets,
// pending/enable bit positions and reset values.
package irq_timer_pkg;

    localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
    localparam logic [4:0] IRQ_EN_OFF      = 5'h10;
    localparam logic [4:0] IRQ_PEND_OFF    = 5'h14;

    localparam int unsigned IRQ_TIMER_BIT = 0;
    localparam int unsigned IRQ_EXT_BIT   = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Byte offset to word-aligned offset; the two low address bits are don't-care.
    function automatic logic [4:0] word_off(input logic [4:0] addr);
        return addr & 5'b11100;
    endfunction

endpackage

// File: rtl/irq_timer_ctrl_sync.sv
// Two-flop synchronizer for an asynchronous request line followed by a
// single-cycle rising-edge pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Metastability filter plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~dly_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Machine-mode interrupt source: 64-bit mtime/mtimecmp pair with prescaler,
// edge-latched external request, and a small word-addressed MMIO slave.
module irq_timer_ctrl
    import irq_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        ext_irq,
    output logic        interrupt
);

    localparam logic [15:0] PRESC_TC = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  en_q, en_d;
    logic        ext_pend_q, ext_pend_d;
    logic        irq_q, irq_d;

    logic        tick_s;
    logic        wr_s;
    logic        rd_s;
    logic [4:0]  off_s;
    logic        ext_rise_s;
    logic        timer_pend_s;

    irq_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ext_irq),
        .rise_o  (ext_rise_s)
    );

    assign off_s        = word_off(bus_addr);
    assign wr_s         = bus_sel & bus_we;
    assign rd_s         = bus_sel & ~bus_we;
    assign tick_s       = (presc_q == PRESC_TC);
    assign timer_pend_s = (mtime_q >= mtimecmp_q);

    // Prescaler runs freely; software writes to mtime do not disturb its phase.
    always_comb begin
        presc_d = presc_q;
        if (tick_s) begin
            presc_d = 16'd0;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // A write to either mtime half blocks the whole 64-bit increment that cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_s && (off_s == MTIME_LO_OFF)) begin
            mtime_d[31:0] = bus_wdata;
        end else if (wr_s && (off_s == MTIME_HI_OFF)) begin
            mtime_d[63:32] = bus_wdata;
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
    end

    // Compare, enable and external-pending next state; an edge beats a W1C.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        ext_pend_d = ext_pend_q;
        if (wr_s && (off_s == MTIMECMP_LO_OFF)) begin
            mtimecmp_d[31:0] = bus_wdata;
        end else if (wr_s && (off_s == MTIMECMP_HI_OFF)) begin
            mtimecmp_d[63:32] = bus_wdata;
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        if (wr_s && (off_s == IRQ_EN_OFF)) begin
            en_d = bus_wdata[1:0];
        end else begin
            en_d = en_q;
        end
        if (ext_rise_s) begin
            ext_pend_d = 1'b1;
        end else if (wr_s && (off_s == IRQ_PEND_OFF) && bus_wdata[IRQ_EXT_BIT]) begin
            ext_pend_d = 1'b0;
        end else begin
            ext_pend_d = ext_pend_q;
        end
        irq_d = (timer_pend_s & en_q[IRQ_TIMER_BIT]) | (ext_pend_q & en_q[IRQ_EXT_BIT]);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
            en_q       <= 2'b00;
            ext_pend_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            ext_pend_q <= ext_pend_d;
            irq_q      <= irq_d;
        end
    end

    assign interrupt = irq_q;

    // Read mux; zero whenever no read is in progress.
    always_comb begin
        bus_rdata = 32'd0;
        if (rd_s) begin
            case (off_s)
                MTIME_LO_OFF:    bus_rdata = mtime_q[31:0];
                MTIME_HI_OFF:    bus_rdata = mtime_q[63:32];
                MTIMECMP_LO_OFF: bus_rdata = mtimecmp_q[31:0];
                MTIMECMP_HI_OFF: bus_rdata = mtimecmp_q[63:32];
                IRQ_EN_OFF:      bus_rdata = {30'd0, en_q};
                IRQ_PEND_OFF:    bus_rdata = {30'd0, ext_pend_q, timer_pend_s};
                default:         bus_rdata = 32'd0;
            endcase
        end else begin
            bus_rdata = 32'd0;
        end
    end

endmodule
